dma_rx_pkt_fifo: RTL and testbench
==================================

// Module: dma_rx_pkt_fifo
// PURPOSE
//  Store-and-forward packet FIFO directly downstream of the PCIe DMA engine's M_AXIS (256b) port.
//  Validates each packet's actual byte count against TUSER[15:0] and forwards only complete, well-formed
//  packets to the datapath; drops malformed/overflowing packets so the pipeline never sees a partial frame.
// PARAMETERS
//  C_DATA_WIDTH   256  TDATA width (bits); TSTRB = C_DATA_WIDTH/8
//  C_TUSER_WIDTH  128  TUSER width; [15:0]=pkt len bytes, [23:16]=src port, [31:24]=dst port
//  C_ADDR_WIDTH   6    log2 FIFO depth in beats (64 beats = 2048 B)
// PORTS
//  axis_aclk       in   1     single clock for all logic
//  axis_resetn     in   1     synchronous, active-low reset
//  S_AXIS_TDATA    in   256   beat data from DMA
//  S_AXIS_TSTRB    in   32    byte strobe
//  S_AXIS_TUSER    in   128   metadata, sampled on first beat of packet
//  S_AXIS_TVALID   in   1     beat valid
//  S_AXIS_TREADY   out  1     beat accept
//  S_AXIS_TLAST    in   1     last beat of packet
//  M_AXIS_TDATA    out  256   forwarded data
//  M_AXIS_TSTRB    out  32    forwarded strobe
//  M_AXIS_TUSER    out  128   forwarded metadata (held constant across packet)
//  M_AXIS_TVALID   out  1     registered valid
//  M_AXIS_TREADY   in   1     downstream accept
//  M_AXIS_TLAST    out  1     last beat
//  drop_len_cnt    out  32    packets dropped on length/strobe error (see CONFIGURATION)
//  drop_ovf_cnt    out  32    packets dropped on FIFO overflow (see CONFIGURATION)
// BEHAVIOUR
//  Reset (axis_resetn==0 at posedge): wr/commit/rd pointers=0, state=IDLE, S_AXIS_TREADY=0, M_AXIS_TVALID=0,
//   M_AXIS_TLAST=0, counters=0. TREADY=1 from first cycle after reset release; never deasserts (drop, not stall).
//  Pointers C_ADDR_WIDTH+1 bits; full when wr_ptr-rd_ptr==2**C_ADDR_WIDTH; wrap via MSB.
//  Memory entry = {TLAST,TUSER,TSTRB,TDATA}; beat written at wr_ptr only when accepted and state!=DROP.
//  Write FSM: IDLE -> first beat: latch len=TUSER[15:0], bytes=0, bad=0; -> PKT if !TLAST.
//   PKT: each beat bytes+=32 on non-last beats (bad=1 if TSTRB!=all-ones); last beat bytes+=popcount(TSTRB).
//   On TLAST: good iff !bad && bytes==len && len!=0 -> commit_ptr<=wr_ptr+1; else wr_ptr<=commit_ptr,
//   drop_len_cnt++ ; -> IDLE. Single-beat packet (TLAST on first beat) is checked in the same cycle.
//   Overflow: beat arrives while full -> wr_ptr<=commit_ptr, drop_ovf_cnt++, -> DROP (or IDLE if that beat has TLAST).
//   DROP: accept and discard beats until TLAST -> IDLE. Packets larger than depth always hit overflow path.
//  Read side: entries in [rd_ptr, commit_ptr) only; 1-cycle RAM read into output register plus 1-entry
//   skid so M_AXIS_TVALID is registered and sustains 1 beat/clk. First beat of a committed packet appears
//   on M_AXIS 2 cycles after the commit edge if output idle. M_AXIS_* stable while TVALID && !TREADY.
//  Simultaneous commit and read, or rollback and read: read side sees only old commit_ptr that cycle; no hazard.
//  Reset mid-packet: partial data discarded; trailing fragment after release parsed as new packet and dropped
//   by length check. Counters saturate at 32'hFFFF_FFFF.
// CONFIGURATION
//  DMA_RX_FIFO_STATS_EN defined: drop_len_cnt/drop_ovf_cnt implemented as above.
//  Not defined: both outputs tied to 32'h0, counter logic removed; drop behaviour unchanged.
// STRUCTURE
//  Shared package: TUSER field offsets (LEN_LO/HI, SRC_PORT, DST_PORT), beat byte count constant, FSM enum.
//  One sub-module: dma_rx_fifo_ram (simple dual-port, 1-cycle registered read, width 417, depth 2**C_ADDR_WIDTH).
// TESTING
//  64B pkt, 2 full beats, TUSER len=64 -> 2 beats out, TUSER/TLAST intact, drop counts 0.
//  70B pkt, last TSTRB=32'h0000003F, len=70 -> forwarded; same with len=72 -> dropped, drop_len_cnt=1.
//  Mid-packet TSTRB=32'h0000FFFF on non-last beat -> dropped, drop_len_cnt++, next good pkt passes.
//  M_AXIS_TREADY=0, send 3000B pkt (94 beats) -> TREADY stays 1, pkt dropped, drop_ovf_cnt=1, FIFO empty.
//  Back-to-back 60B pkts, TREADY random 50% -> all delivered in order, no data/tuser corruption.
//  Reset asserted mid-packet for 1 cycle -> outputs zeroed, tail fragment dropped, following pkt forwarded.

Source files
------------

// File: rtl/dma_rx_pkt_fifo_pkg.sv
// Shared definitions for the DMA RX store-and-forward packet FIFO:
// TUSER field offsets, beat byte count, write FSM states and a strobe popcount.
package dma_rx_pkt_fifo_pkg;

  localparam int LEN_LO      = 0;
  localparam int LEN_HI      = 15;
  localparam int SRC_PORT_LO = 16;
  localparam int SRC_PORT_HI = 23;
  localparam int DST_PORT_LO = 24;
  localparam int DST_PORT_HI = 31;

  localparam int BEAT_BYTES  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/dma_rx_fifo_ram.sv
// Simple dual-port RAM for the packet FIFO: one write port, one read port
// with a single registered read cycle.
module dma_rx_fifo_ram #(
  parameter int WIDTH  = 417,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dma_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: commits only packets whose byte count matches TUSER length.
// Drop statistics counters exist only when DMA_RX_FIFO_STATS_EN is defined.
module dma_rx_pkt_fifo
  import dma_rx_pkt_fifo_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_ADDR_WIDTH  = 6
) (
  input  logic                       axis_aclk,
  input  logic                       axis_resetn,
  input  logic [C_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  input  logic                       S_AXIS_TLAST,
  output logic [C_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                       M_AXIS_TVALID,
  input  logic                       M_AXIS_TREADY,
  output logic                       M_AXIS_TLAST,
  output logic [31:0]                drop_len_cnt,
  output logic [31:0]                drop_ovf_cnt
);

  localparam int STRB_W  = C_DATA_WIDTH / 8;
  localparam int BODY_W  = C_TUSER_WIDTH + STRB_W + C_DATA_WIDTH;
  localparam int ENTRY_W = 1 + BODY_W;
  localparam int DEPTH   = 2 ** C_ADDR_WIDTH;

  typedef logic [C_ADDR_WIDTH:0] ptr_t;

  wr_state_e state, state_nxt;
  ptr_t wr_ptr, commit_ptr, rd_ptr;
  logic tready_q;

  logic [15:0]              len_q, bytes_q;
  logic                     bad_q;
  logic [C_TUSER_WIDTH-1:0] user_q;

  logic                     accept, full, first;
  logic [15:0]              len_cur, bytes_cur, bytes_last;
  logic                     bad_cur, pkt_good;
  logic [C_TUSER_WIDTH-1:0] user_cur;
  logic                     wr_en, ovf, commit, rollback_len;
  logic [ENTRY_W-1:0]       wdata;

  assign accept = S_AXIS_TVALID && tready_q;
  assign full   = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
  assign first  = (state == ST_IDLE);

  // The first beat of a packet sees fresh TUSER; later beats use the latched header.
  assign len_cur    = first ? S_AXIS_TUSER[LEN_HI:LEN_LO] : len_q;
  assign bytes_cur  = first ? 16'd0 : bytes_q;
  assign bad_cur    = first ? 1'b0 : bad_q;
  assign user_cur   = first ? S_AXIS_TUSER : user_q;
  assign bytes_last = bytes_cur + {10'd0, popcount32(S_AXIS_TSTRB)};
  assign pkt_good   = !bad_cur && (bytes_last == len_cur) && (len_cur != 16'd0);
  assign wdata      = {S_AXIS_TLAST, user_cur, S_AXIS_TSTRB, S_AXIS_TDATA};

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        ST_IDLE, ST_PKT: begin
          if (S_AXIS_TLAST) begin
            state_nxt = ST_IDLE;
          end else if (full) begin
            state_nxt = ST_DROP;
          end else begin
            state_nxt = ST_PKT;
          end
        end
        ST_DROP: begin
          if (S_AXIS_TLAST) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en        = 1'b0;
    ovf          = 1'b0;
    commit       = 1'b0;
    rollback_len = 1'b0;
    if (accept && (state != ST_DROP)) begin
      if (full) begin
        ovf = 1'b1;
      end else begin
        wr_en        = 1'b1;
        commit       = S_AXIS_TLAST && pkt_good;
        rollback_len = S_AXIS_TLAST && !pkt_good;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      tready_q   <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (ovf || rollback_len) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (commit) begin
        commit_ptr <= wr_ptr + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
      len_q   <= len_cur;
      bytes_q <= bytes_cur + 16'(BEAT_BYTES);
      bad_q   <= bad_cur | ~(&S_AXIS_TSTRB);
      user_q  <= user_cur;
    end
  end

  assign S_AXIS_TREADY = tready_q;

  // ---- read stage p0: issue a RAM read when a committed entry exists and there is room downstream
  logic                 vld_p0, vld_p1, vld_p2, skid_vld, last_p2, pop;
  logic [1:0]           occ;
  logic [ENTRY_W-1:0]   ram_p1, skid_q, src_p1;
  logic [BODY_W-1:0]    body_p2;
  logic                 load_out;

  assign pop      = vld_p2 && M_AXIS_TREADY;
  assign occ      = {1'b0, vld_p1} + {1'b0, vld_p2} + {1'b0, skid_vld};
  assign vld_p0   = (rd_ptr != commit_ptr) && ((occ - {1'b0, pop}) < 2'd2);
  assign load_out = !vld_p2 || pop;
  assign src_p1   = skid_vld ? skid_q : ram_p1;

  dma_rx_fifo_ram #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (C_ADDR_WIDTH)
  ) u_ram (
    .clk   (axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr[C_ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (vld_p0),
    .raddr (rd_ptr[C_ADDR_WIDTH-1:0]),
    .rdata (ram_p1)
  );

  // ---- read stage p1 -> p2: RAM output lands in the output register, or in the skid slot on stall
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      rd_ptr   <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      skid_vld <= 1'b0;
      last_p2  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + ptr_t'(vld_p0);
      vld_p1 <= vld_p0;
      if (load_out) begin
        vld_p2   <= skid_vld || vld_p1;
        skid_vld <= skid_vld && vld_p1;
        if (skid_vld || vld_p1) begin
          last_p2 <= src_p1[ENTRY_W-1];
        end
      end else begin
        skid_vld <= skid_vld || vld_p1;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (load_out && (skid_vld || vld_p1)) begin
      body_p2 <= src_p1[BODY_W-1:0];
    end
    if (vld_p1 && (skid_vld || !load_out)) begin
      skid_q <= ram_p1;
    end
  end

  assign M_AXIS_TVALID = vld_p2;
  assign M_AXIS_TLAST  = last_p2;
  assign {M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = body_p2;

`ifdef DMA_RX_FIFO_STATS_EN
  logic [31:0] len_cnt, ovf_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      len_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (rollback_len) begin
        len_cnt <= sat_inc(len_cnt);
      end
      if (ovf) begin
        ovf_cnt <= sat_inc(ovf_cnt);
      end
    end
  end

  assign drop_len_cnt = len_cnt;
  assign drop_ovf_cnt = ovf_cnt;
`else
  assign drop_len_cnt = 32'h0;
  assign drop_ovf_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dma_rx_pkt_fifo.sv
// Directed bench for dma_rx_pkt_fifo: packet table plus overflow, random-backpressure
// and mid-packet reset sequences. Counter expectations follow DMA_RX_FIFO_STATS_EN.
module tb_dma_rx_pkt_fifo;

  typedef logic [416:0] beat_t;

  typedef struct {
    int          nbeats;
    int          len;
    logic [31:0] last_strb;
    int          bad_beat;
    logic [31:0] bad_strb;
    bit          fwd;
  } vec_t;

`ifdef DMA_RX_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         axis_resetn = 1'b0;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic [31:0]  drop_len_cnt, drop_ovf_cnt;

  int    n_vec = 0;
  int    n_err = 0;
  int    ready_mode = 1;
  bit    tready_low = 1'b0;
  beat_t exp_q[$];
  beat_t rx_q[$];

  always #5 clk = ~clk;

  dma_rx_pkt_fifo dut (
    .axis_aclk     (clk),
    .axis_resetn   (axis_resetn),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TUSER  (s_tuser),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TLAST  (m_tlast),
    .drop_len_cnt  (drop_len_cnt),
    .drop_ovf_cnt  (drop_ovf_cnt)
  );

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_tready = 1'b0;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (axis_resetn && m_tvalid && m_tready) begin
      rx_q.push_back({m_tlast, m_tuser, m_tstrb, m_tdata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ecnt(input int n);
    return STATS ? 32'(n) : 32'h0;
  endfunction

  function automatic logic [127:0] mk_user(input int tag, input int len);
    logic [31:0] t;
    logic [7:0]  dst;
    t   = tag;
    dst = t[7:0] + 8'd1;
    return {t, ~t, t ^ 32'h5A5A_5A5A, dst, t[7:0], 16'(len)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s beat: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drives beats b_from..b_to of a packet; caller is just past a rising edge.
  task automatic send_pkt(input int tag, input int nbeats, input int len, input logic [31:0] last_strb,
                          input int bad_beat, input logic [31:0] bad_strb, input bit fwd,
                          input int b_from, input int b_to);
    logic [127:0] u;
    u = mk_user(tag, len);
    for (int b = b_from; b <= b_to; b++) begin
      logic [15:0] t16, b16;
      t16 = 16'(tag);
      b16 = 16'(b);
      s_tdata  = {8{t16, b16}};
      s_tstrb  = (b == nbeats - 1) ? last_strb : ((b == bad_beat) ? bad_strb : 32'hFFFF_FFFF);
      s_tuser  = (b == 0) ? u : ~u;
      s_tlast  = (b == nbeats - 1);
      s_tvalid = 1'b1;
      if (fwd) exp_q.push_back({s_tlast, u, s_tstrb, s_tdata});
      @(negedge clk);
      if (!s_tready) tready_low = 1'b1;
      for (int w = 0; w < 100 && !s_tready; w++) @(negedge clk);
      if (!s_tready) begin
        n_vec++;
        n_err++;
        $display("FAIL send tag %0d: S_AXIS_TREADY stuck low, got 0 expected 1", tag);
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_out(input string nm);
    beat_t a, e;
    for (int c = 0; c < 3000 && rx_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk({nm, " beat count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      a = rx_q.pop_front();
      e = exp_q.pop_front();
      chk_beat(nm, a, e);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vt[10];
    int   exp_len;
    exp_len = 0;
    vt[0] = '{2,  64, 32'hFFFF_FFFF, -1, 32'h0,         1'b1};
    vt[1] = '{3,  70, 32'h0000_003F, -1, 32'h0,         1'b1};
    vt[2] = '{3,  72, 32'h0000_003F, -1, 32'h0,         1'b0};
    vt[3] = '{3,  96, 32'hFFFF_FFFF,  0, 32'h0000_FFFF, 1'b0};
    vt[4] = '{2,  64, 32'hFFFF_FFFF, -1, 32'h0,         1'b1};
    vt[5] = '{1,  32, 32'hFFFF_FFFF, -1, 32'h0,         1'b1};
    vt[6] = '{1,   0, 32'h0000_0000, -1, 32'h0,         1'b0};
    vt[7] = '{1,   5, 32'h0000_001F, -1, 32'h0,         1'b1};
    vt[8] = '{2,  40, 32'h0000_00FF, -1, 32'h0,         1'b1};
    vt[9] = '{4, 128, 32'h7FFF_FFFF, -1, 32'h0,         1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset tready", s_tready, 0);
    chk("reset tvalid", m_tvalid, 0);
    chk("reset tlast", m_tlast, 0);
    chk("reset drop_len", drop_len_cnt, 0);
    chk("reset drop_ovf", drop_ovf_cnt, 0);
    axis_resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready after release", s_tready, 1);

    for (int i = 0; i < 10; i++) begin
      send_pkt(100 + i, vt[i].nbeats, vt[i].len, vt[i].last_strb, vt[i].bad_beat, vt[i].bad_strb,
               vt[i].fwd, 0, vt[i].nbeats - 1);
      if (!vt[i].fwd) exp_len++;
      check_out($sformatf("vec%0d", i));
      chk($sformatf("vec%0d drop_len", i), drop_len_cnt, ecnt(exp_len));
    end
    chk("table drop_ovf", drop_ovf_cnt, 0);

    // Oversized packet with the output stalled: must be dropped without backpressure.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    tready_low = 1'b0;
    send_pkt(200, 94, 3000, 32'h00FF_FFFF, -1, 32'h0, 1'b0, 0, 93);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf tready held", 32'(tready_low), 0);
    chk("ovf drop_ovf", drop_ovf_cnt, ecnt(1));
    chk("ovf drop_len", drop_len_cnt, ecnt(exp_len));
    chk("ovf fifo empty", m_tvalid, 0);
    ready_mode = 1;
    check_out("ovf nothing out");
    send_pkt(201, 2, 64, 32'hFFFF_FFFF, -1, 32'h0, 1'b1, 0, 1);
    check_out("post ovf pkt");

    // Back-to-back 60-byte packets under random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      send_pkt(300 + k, 2, 60, 32'h0FFF_FFFF, -1, 32'h0, 1'b1, 0, 1);
    end
    check_out("b2b random ready");
    ready_mode = 1;
    chk("b2b drop_len", drop_len_cnt, ecnt(exp_len));

    // Reset in the middle of a packet while a committed beat is stalled at the output.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(400, 1, 32, 32'hFFFF_FFFF, -1, 32'h0, 1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset tvalid", m_tvalid, 1);
    chk("pre-reset tlast", m_tlast, 1);
    send_pkt(401, 4, 128, 32'hFFFF_FFFF, -1, 32'h0, 1'b0, 0, 1);
    axis_resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid reset tvalid", m_tvalid, 0);
    chk("mid reset tlast", m_tlast, 0);
    chk("mid reset tready", s_tready, 0);
    chk("mid reset drop_len", drop_len_cnt, 0);
    axis_resetn = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    chk("post reset tready", s_tready, 1);
    send_pkt(401, 4, 128, 32'hFFFF_FFFF, -1, 32'h0, 1'b0, 2, 3);
    send_pkt(402, 2, 64, 32'hFFFF_FFFF, -1, 32'h0, 1'b1, 0, 1);
    check_out("after reset");
    chk("tail drop_len", drop_len_cnt, ecnt(1));
    chk("tail drop_ovf", drop_ovf_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
